// File: rtl/cpu10_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu10_pkg
//  Description : Shared constants and types for the 10-bit CPU program
//                loader: word/address widths, checksum width and the
//                loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu10_pkg;

    localparam int c_CPU_DATA_W = 10;
    localparam int c_CPU_ADDR_W = 10;
    localparam int c_CHK_W      = c_CPU_DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } ldr_state_e;

endpackage
`default_nettype wire

// File: rtl/loader_checksum.sv
`default_nettype none
// ============================================================================
//  Module      : loader_checksum
//  Description : Clearable modulo-2**W accumulator with enable.
//                o_sum already includes the current-cycle operand when
//                i_en is high, so the owner can compare a running total on
//                the same cycle the final operand arrives.
//  Ports       : clk, rst_n (async active-low), i_clr, i_en, i_data,
//                o_sum (running total including this cycle's operand)
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_checksum
    import cpu10_pkg::*;
#(
    parameter int W = c_CHK_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] r_sum;
    logic [W-1:0] w_add;

    assign w_add = i_en ? i_data : '0;
    assign o_sum = r_sum + w_add;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else begin
            r_sum <= o_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Host-side writer for the 10-bit CPU instruction RAM.
//                Streams program words in over valid/ready, writes them,
//                reads the image back and compares checksums, then releases
//                the CPU from reset and waits for its halt flag.
//  Ports       : clk, rst (async active-low), start,
//                s_valid/s_data/s_last/s_ready   - host word stream
//                imem_we/imem_addr/imem_wdata/imem_rdata - RAM port
//                cpu_rst/cpu_halted              - CPU control
//                busy/done/error/word_count      - status
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import cpu10_pkg::*;
#(
    parameter int DATA_W    = c_CPU_DATA_W,
    parameter int ADDR_W    = c_CPU_ADDR_W,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              cpu_rst,
    input  logic              cpu_halted,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);

    ldr_state_e r_state;
    ldr_state_e w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_word_count;
    logic [ADDR_W:0]   r_rd_cnt;
    logic              r_rd_vld;
    logic              r_done;
    logic              r_error;

    logic              w_full;
    logic              w_start_ok;
    logic              w_beat;
    logic              w_overflow;
    logic              w_rd_issue;
    logic              w_verify_end;
    logic              w_mismatch;
    logic              w_halt;
    logic [DATA_W-1:0] w_ld_sum;
    logic [DATA_W-1:0] w_vf_sum;

    assign w_full     = (r_word_count == c_DEPTH);
    assign imem_addr  = r_addr;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        imem_we      = 1'b0;
        imem_wdata   = '0;
        cpu_rst      = 1'b1;
        busy         = 1'b0;
        w_start_ok   = 1'b0;
        w_beat       = 1'b0;
        w_overflow   = 1'b0;
        w_rd_issue   = 1'b0;
        w_verify_end = 1'b0;
        w_mismatch   = 1'b0;
        w_halt       = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy    = 1'b1;
                s_ready = !w_full;
                if (s_valid && !w_full) begin
                    w_beat     = 1'b1;
                    imem_we    = 1'b1;
                    imem_wdata = s_data;
                    if (s_last) begin
                        w_next_state = ST_VERIFY;
                    end
                end else if (s_valid) begin
                    // A word offered once the window is full is dropped.
                    w_overflow   = 1'b1;
                    w_next_state = ST_ERROR;
                end
            end
            ST_VERIFY: begin
                busy         = 1'b1;
                w_rd_issue   = (r_rd_cnt != r_word_count);
                // All reads issued and the final read data is on imem_rdata.
                w_verify_end = r_rd_vld && !w_rd_issue;
                if (w_verify_end) begin
                    if (w_ld_sum == w_vf_sum) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_mismatch   = 1'b1;
                        w_next_state = ST_ERROR;
                    end
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                cpu_rst = 1'b0;
                if (cpu_halted) begin
                    w_halt       = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address, counters and sticky status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_word_count <= '0;
            r_rd_cnt     <= '0;
            r_rd_vld     <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_issue;
            if (w_start_ok) begin
                r_addr       <= c_BASE;
                r_word_count <= '0;
                r_rd_cnt     <= '0;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
            end
            if (w_beat) begin
                r_word_count <= r_word_count + (ADDR_W+1)'(1);
                // Final beat rewinds the address so readback starts at base.
                r_addr       <= s_last ? c_BASE : (r_addr + ADDR_W'(1));
            end
            if (w_rd_issue) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_rd_cnt <= r_rd_cnt + (ADDR_W+1)'(1);
            end
            if (w_overflow || w_mismatch) begin
                r_error <= 1'b1;
            end
            if (w_halt) begin
                r_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checksums: one over accepted words, one over read-back data
    // ------------------------------------------------------------------
    loader_checksum #(
        .W (DATA_W)
    ) u_chk_load (
        .clk    (clk),
        .rst_n  (rst),
        .i_clr  (w_start_ok),
        .i_en   (w_beat),
        .i_data (s_data),
        .o_sum  (w_ld_sum)
    );

    loader_checksum #(
        .W (DATA_W)
    ) u_chk_verify (
        .clk    (clk),
        .rst_n  (rst),
        .i_clr  (w_start_ok),
        .i_en   (r_rd_vld),
        .i_data (imem_rdata),
        .o_sum  (w_vf_sum)
    );

    // The load window must not wrap past the top of the address space.
    a_no_addr_wrap : assert property (@(posedge clk)
        (BASE_ADDR + DEPTH <= 2**ADDR_W) && (DEPTH >= 1));

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader (DEPTH = 8). Expected
//                RAM writes are queued as words are driven and popped when
//                the loader writes; status is checked against fixed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int DW  = 10;
    localparam int AW  = 10;
    localparam int DEP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic [DW-1:0] imem_rdata;
    logic          cpu_rst;
    logic          cpu_halted = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    always #5 clk = ~clk;

    prog_loader #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEPTH     (DEP),
        .BASE_ADDR (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_rdata (imem_rdata),
        .cpu_rst    (cpu_rst),
        .cpu_halted (cpu_halted),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    // Instruction RAM model: synchronous write, 1-cycle read latency,
    // optional corruption of address 2 on readback.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          corrupt = 1'b0;
    logic          mem_clr = 1'b0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
        end else if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
        end
        imem_rdata <= (corrupt && imem_addr == AW'(2)) ? (mem[imem_addr] ^ DW'(1))
                                                       : mem[imem_addr];
    end

    // ------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_mis = 0;
    int n_wr  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];

    always @(negedge clk) begin
        if (rst && imem_we) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.a));
                chk("wr_data", 32'(imem_wdata), 32'(e.d));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at posedge + 1)
    // ------------------------------------------------------------------
    logic [DW-1:0] img [0:8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] wd, input logic wl, input logic [AW-1:0] wa);
        s_valid = 1'b1;
        s_data  = wd;
        s_last  = wl;
        exp_q.push_back({wa, wd});
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic load(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            beat(img[i], (i == n - 1), AW'(i));
            if (i != n - 1) repeat (gap) tick();
        end
    endtask

    task automatic wait_run(output int cyc);
        cyc = 0;
        while (cpu_rst && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_mem(input int n);
        for (int i = 0; i < n; i++) chk("mem", 32'(mem[i]), 32'(img[i]));
    endtask

    task automatic halt_cpu();
        repeat (20) tick();
        chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("halt_error", 32'(error), 32'd0);
        chk("halt_busy", 32'(busy), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int cyc;
        int w0;

        img[0] = 10'h181; img[1] = 10'h0C4; img[2] = 10'h300; img[3] = 10'h0A2;
        img[4] = 10'h011; img[5] = 10'h3FF; img[6] = 10'h155; img[7] = 10'h2AA;
        img[8] = 10'h077;

        mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;

        // Reset state
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        rst = 1'b1;
        tick();

        // Happy path
        do_start();
        chk("load_ready", 32'(s_ready), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        load(4, 0);
        wait_run(cyc);
        chk("happy_verify_len", 32'(cyc), 32'd5);
        chk("happy_word_count", 32'(word_count), 32'd4);
        check_mem(4);
        halt_cpu();
        chk("happy_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: one idle cycle between beats
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        w0 = n_wr;
        do_start();
        load(4, 1);
        wait_run(cyc);
        chk("bp_verify_len", 32'(cyc), 32'd5);
        chk("bp_word_count", 32'(word_count), 32'd4);
        chk("bp_writes", 32'(n_wr - w0), 32'd4);
        check_mem(4);
        chk("bp_mem_past_end", 32'(mem[4]), 32'd0);
        halt_cpu();

        // start ignored during LOAD and RUN
        do_start();
        beat(img[0], 1'b0, AW'(0));
        beat(img[1], 1'b0, AW'(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_load_wc", 32'(word_count), 32'd2);
        chk("ign_load_addr", 32'(imem_addr), 32'd2);
        chk("ign_load_busy", 32'(busy), 32'd1);
        beat(img[2], 1'b0, AW'(2));
        beat(img[3], 1'b1, AW'(3));
        wait_run(cyc);
        chk("ign_verify_len", 32'(cyc), 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_run_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("ign_run_busy", 32'(busy), 32'd1);
        chk("ign_run_wc", 32'(word_count), 32'd4);
        halt_cpu();

        // Verify mismatch
        corrupt = 1'b1;
        do_start();
        load(4, 0);
        cyc = 0;
        while (!error && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("mis_verify_len", 32'(cyc), 32'd5);
        chk("mis_error", 32'(error), 32'd1);
        chk("mis_done", 32'(done), 32'd0);
        chk("mis_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("mis_cpu_rst", 32'(cpu_rst), 32'd1);
        corrupt = 1'b0;

        // Overflow: 9 words into an 8-word window, no s_last
        w0 = n_wr;
        do_start();
        chk("ovf_error_cleared", 32'(error), 32'd0);
        for (int i = 0; i < DEP; i++) beat(img[i], 1'b0, AW'(i));
        chk("ovf_full_wc", 32'(word_count), 32'(DEP));
        s_valid = 1'b1;
        s_data  = img[8];
        #1;
        chk("ovf_ready_full", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1 s_valid = 1'b0;
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_ready", 32'(s_ready), 32'd0);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("ovf_writes", 32'(n_wr - w0), 32'(DEP));
        check_mem(DEP);

        // Reset in the middle of a load
        do_start();
        beat(img[0], 1'b0, AW'(0));
        beat(img[1], 1'b0, AW'(1));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wc", 32'(word_count), 32'd0);
        chk("mid_rst_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_rst_error", 32'(error), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        do_start();
        load(3, 0);
        wait_run(cyc);
        chk("reload_verify_len", 32'(cyc), 32'd4);
        chk("reload_wc", 32'(word_count), 32'd3);
        chk("reload_error", 32'(error), 32'd0);
        check_mem(3);
        halt_cpu();
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
